// File: rtl/aidan_mcnay_prime_host_pkg.sv
// Shared definitions for the prime-detector host initiator: state encoding
// and counter-width helpers used by the top and its shift register.
package aidan_mcnay_prime_host_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] S_SHIFT_LO  = 3'd1;
   localparam logic [STATE_W-1:0] S_SHIFT_HI  = 3'd2;
   localparam logic [STATE_W-1:0] S_CS_REL    = 3'd3;
   localparam logic [STATE_W-1:0] S_READY     = 3'd4;
   localparam logic [STATE_W-1:0] S_WAIT_LOW  = 3'd5;
   localparam logic [STATE_W-1:0] S_WAIT_HIGH = 3'd6;
   localparam logic [STATE_W-1:0] S_RESP      = 3'd7;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = S_IDLE,
      ST_SHIFT_LO  = S_SHIFT_LO,
      ST_SHIFT_HI  = S_SHIFT_HI,
      ST_CS_REL    = S_CS_REL,
      ST_READY     = S_READY,
      ST_WAIT_LOW  = S_WAIT_LOW,
      ST_WAIT_HIGH = S_WAIT_HIGH,
      ST_RESP      = S_RESP
   } state_t;

   // Phase counter counts 0..max(half_period, ready_hold)-1.
   function automatic int unsigned phase_cnt_w(input int unsigned hp,
                                                input int unsigned rh);
      int unsigned m;
      m = (hp > rh) ? hp : rh;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   // Bit counter must hold the value nbits itself.
   function automatic int unsigned bit_cnt_w(input int unsigned nb);
      return $clog2(nb + 1);
   endfunction

endpackage

// File: rtl/aidan_mcnay_piso.sv
// Parallel-in serial-out shift register, MSB first, zero fill.
// Ports: clk, reset (async, active high), load (capture data_in),
//        en (shift left by one), data_in[nbits-1:0], data_out (current MSB).
module aidan_mcnay_piso
   import aidan_mcnay_prime_host_pkg::*;
#(
   parameter int unsigned nbits = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [nbits-1:0] data_in,
   output logic             data_out
);

   logic [nbits-1:0] sr;

   // Zero fill means the register is empty once every bit has gone out,
   // so data_out idles low between words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= data_in;
      end else if (en) begin
         sr <= {sr[nbits-2:0], 1'b0};
      end
   end

   assign data_out = sr[nbits-1];

endmodule

// File: rtl/aidan_mcnay_prime_host.sv
// Host-side serial initiator for the prime detector. Takes an operand on a
// val/rdy request port, shifts it out MSB-first on SDI/SCLK/CS, pulses
// ready, waits for a fresh done edge and returns is_prime on a val/rdy
// response port.
// Ports: clk, reset (async, active high)
//        req_val/req_rdy/req_data     operand request
//        resp_val/resp_rdy/resp_is_prime  result response
//        SDI, SCLK, CS (active low), ready  serial pins to the detector
//        done, is_prime  asynchronous detector outputs
module aidan_mcnay_prime_host
   import aidan_mcnay_prime_host_pkg::*;
#(
   parameter int unsigned nbits       = 32,
   parameter int unsigned half_period = 8,
   parameter int unsigned ready_hold  = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [nbits-1:0] req_data,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic             resp_is_prime,
   output logic             SDI,
   output logic             SCLK,
   output logic             CS,
   output logic             ready,
   input  logic             done,
   input  logic             is_prime
);

   localparam int unsigned PW = phase_cnt_w(half_period, ready_hold);
   localparam int unsigned BW = bit_cnt_w(nbits);

   localparam logic [PW-1:0] HP_LAST = PW'(half_period - 1);
   localparam logic [PW-1:0] RH_LAST = PW'(ready_hold - 1);
   localparam logic [BW-1:0] NB_LOAD = BW'(nbits);
   localparam logic [BW-1:0] NB_LAST = BW'(1);

   state_t        state;
   logic [PW-1:0] phase;
   logic [BW-1:0] bit_cnt;
   logic          done_m, done_s;
   logic          prime_m, prime_s;
   logic          piso_load;
   logic          piso_en;

   assign piso_load = (state == ST_IDLE) && req_val && req_rdy;
   assign piso_en   = (state == ST_SHIFT_HI) && (phase == HP_LAST);

   // SDI is the shift register MSB directly; it is already zero in idle and
   // during CS release because every loaded bit has been shifted out.
   aidan_mcnay_piso #(.nbits(nbits)) u_piso (
      .clk      (clk),
      .reset    (reset),
      .load     (piso_load),
      .en       (piso_en),
      .data_in  (req_data),
      .data_out (SDI)
   );

   // Sequencer, serial pin drivers and detector-output synchronizers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         req_rdy       <= 1'b1;
         resp_val      <= 1'b0;
         resp_is_prime <= 1'b0;
         SCLK          <= 1'b0;
         CS            <= 1'b1;
         ready         <= 1'b0;
         phase         <= '0;
         bit_cnt       <= '0;
         done_m        <= 1'b0;
         done_s        <= 1'b0;
         prime_m       <= 1'b0;
         prime_s       <= 1'b0;
      end else begin
         done_m  <= done;
         done_s  <= done_m;
         prime_m <= is_prime;
         prime_s <= prime_m;

         case (state)
            ST_IDLE: begin
               if (req_val && req_rdy) begin
                  req_rdy <= 1'b0;
                  CS      <= 1'b0;
                  SCLK    <= 1'b0;
                  phase   <= '0;
                  bit_cnt <= NB_LOAD;
                  state   <= ST_SHIFT_LO;
               end
            end
            ST_SHIFT_LO: begin
               if (phase == HP_LAST) begin
                  phase <= '0;
                  SCLK  <= 1'b1;
                  state <= ST_SHIFT_HI;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_SHIFT_HI: begin
               if (phase == HP_LAST) begin
                  phase   <= '0;
                  SCLK    <= 1'b0;
                  bit_cnt <= bit_cnt - 1'b1;
                  if (bit_cnt == NB_LAST) begin
                     CS    <= 1'b1;
                     state <= ST_CS_REL;
                  end else begin
                     state <= ST_SHIFT_LO;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_CS_REL: begin
               if (phase == HP_LAST) begin
                  phase <= '0;
                  ready <= 1'b1;
                  state <= ST_READY;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_READY: begin
               if (phase == RH_LAST) begin
                  phase <= '0;
                  ready <= 1'b0;
                  state <= ST_WAIT_LOW;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            // A done still high from the previous operand must be seen low
            // before a rising done is trusted.
            ST_WAIT_LOW: begin
               if (!done_s) begin
                  state <= ST_WAIT_HIGH;
               end
            end
            ST_WAIT_HIGH: begin
               if (done_s) begin
                  resp_is_prime <= prime_s;
                  resp_val      <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_rdy) begin
                  resp_val <= 1'b0;
                  req_rdy  <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aidan_mcnay_prime_host.sv
// Bench for aidan_mcnay_prime_host with a behavioural prime detector on the
// far side of the serial pins. Expected frames and results are queued when
// a request is issued; monitors pop and compare as the DUT produces them.
module tb_aidan_mcnay_prime_host;

   localparam int unsigned NB     = 8;
   localparam int unsigned HP     = 4;
   localparam int unsigned RH     = 4;
   localparam int unsigned CLK_NS = 10;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          req_val   = 1'b0;
   logic [NB-1:0] req_data  = '0;
   logic          resp_rdy  = 1'b1;
   logic          done      = 1'b0;
   logic          is_prime  = 1'b0;
   logic          req_rdy, resp_val, resp_is_prime;
   logic          SDI, SCLK, CS, ready;

   int total = 0;
   int bad   = 0;

   logic [NB-1:0] exp_word_q[$];
   bit            exp_resp_q[$];
   int            n_exp      = 0;
   int            resp_count = 0;
   bit            stale_mode = 1'b0;

   logic [NB-1:0] rx_word   = '0;
   logic [NB-1:0] last_word = '0;
   int            rx_bits   = 0;
   time           t_cs_fall = 0;
   time           t_cs_rise = 0;
   time           t_rdy     = 0;

   aidan_mcnay_prime_host #(
      .nbits       (NB),
      .half_period (HP),
      .ready_hold  (RH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_val       (req_val),
      .req_rdy       (req_rdy),
      .req_data      (req_data),
      .resp_val      (resp_val),
      .resp_rdy      (resp_rdy),
      .resp_is_prime (resp_is_prime),
      .SDI           (SDI),
      .SCLK          (SCLK),
      .CS            (CS),
      .ready         (ready),
      .done          (done),
      .is_prime      (is_prime)
   );

   always #(CLK_NS/2) clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic bit prime8(input logic [NB-1:0] v);
      if (v < 2) return 1'b0;
      for (int d = 2; d * d <= int'(v); d++)
         if (int'(v) % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Serial frame monitor: collect SDI at SCLK rises while CS is low.
   always @(negedge CS) begin
      rx_word   = '0;
      rx_bits   = 0;
      t_cs_fall = $time;
   end

   always @(posedge SCLK) begin
      if (!CS) begin
         rx_word = {rx_word[NB-2:0], SDI};
         rx_bits++;
      end
   end

   always @(posedge CS) begin
      t_cs_rise = $time;
      if (!reset) begin
         last_word = rx_word;
         if (exp_word_q.size() == 0) begin
            fail("unexpected_frame");
         end else begin
            chk("sdi_word", 32'(rx_word), 32'(exp_word_q.pop_front()));
            chk("sclk_rises", 32'(rx_bits), 32'(NB));
            chk("cs_low_cycles", 32'((t_cs_rise - t_cs_fall) / CLK_NS), 32'(2 * NB * HP));
         end
      end
   end

   // Ready pulse placement and width.
   always @(posedge ready) begin
      if (!reset) begin
         t_rdy = $time;
         chk("ready_delay", 32'((t_rdy - t_cs_rise) / CLK_NS), 32'(HP));
      end
   end

   always @(negedge ready) begin
      if (!reset && t_rdy != 0)
         chk("ready_width", 32'(($time - t_rdy) / CLK_NS), 32'(RH));
   end

   // Response scoreboard: compare on each accepted response.
   always @(negedge clk) begin
      if (!reset && resp_val === 1'b1 && resp_rdy) begin
         if (exp_resp_q.size() == 0) begin
            fail("unexpected_resp");
         end else begin
            chk("resp_is_prime", 32'(resp_is_prime), 32'(exp_resp_q.pop_front()));
         end
         resp_count++;
      end
   end

   // Behavioural detector: on ready, drop done, then report the result.
   initial begin
      logic [NB-1:0] w;
      forever begin
         @(posedge ready);
         w = last_word;
         if (stale_mode) begin
            repeat (20) @(posedge clk);
            #1 done = 1'b0;
            repeat (6) @(posedge clk);
            #1;
         end else begin
            #1 done = 1'b0;
            repeat (5) @(posedge clk);
            #1;
         end
         is_prime = prime8(w);
         done     = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req_rdy();
      for (int k = 0; k < 2000; k++) begin
         if (req_rdy) return;
         tick();
      end
      fail("req_rdy_timeout");
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 2000; k++) begin
         if (ready) return;
         tick();
      end
      fail("ready_timeout");
   endtask

   task automatic wait_resps();
      for (int k = 0; k < 3000; k++) begin
         if (resp_count >= n_exp) return;
         tick();
      end
      fail("resp_timeout");
   endtask

   task automatic send(input logic [NB-1:0] w, input bit exp_prime, input bit expect_done);
      wait_req_rdy();
      if (expect_done) begin
         exp_word_q.push_back(w);
         exp_resp_q.push_back(exp_prime);
         n_exp++;
      end
      req_val  = 1'b1;
      req_data = w;
      tick();
      req_val = 1'b0;
      chk("cs_fall_after_handshake", 32'(CS), 32'(0));
      chk("req_rdy_busy", 32'(req_rdy), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      repeat (3) tick();
      chk("rst_req_rdy", 32'(req_rdy), 32'(1));
      chk("rst_resp_val", 32'(resp_val), 32'(0));
      chk("rst_resp_is_prime", 32'(resp_is_prime), 32'(0));
      chk("rst_sdi", 32'(SDI), 32'(0));
      chk("rst_sclk", 32'(SCLK), 32'(0));
      chk("rst_cs", 32'(CS), 32'(1));
      chk("rst_ready", 32'(ready), 32'(0));
      reset = 1'b0;
      tick();

      // 0xA5 framing, then simple prime / composite results.
      send(8'hA5, 1'b0, 1'b1);
      wait_resps();
      send(8'd7, 1'b1, 1'b1);
      wait_resps();
      send(8'd9, 1'b0, 1'b1);
      wait_resps();

      // Back-pressured response with a stray request in the window.
      resp_rdy = 1'b0;
      send(8'd13, 1'b1, 1'b1);
      for (int k = 0; k < 2000 && !resp_val; k++) tick();
      chk("hold_resp_seen", 32'(resp_val), 32'(1));
      for (int i = 0; i < 10; i++) begin
         tick();
         req_val  = (i == 3);
         req_data = 8'h55;
         chk("hold_resp_val", 32'(resp_val), 32'(1));
         chk("hold_resp_is_prime", 32'(resp_is_prime), 32'(1));
         chk("hold_req_rdy", 32'(req_rdy), 32'(0));
      end
      req_val  = 1'b0;
      resp_rdy = 1'b1;
      wait_resps();
      chk("req_rdy_after_resp", 32'(req_rdy), 32'(1));
      chk("resp_val_after_resp", 32'(resp_val), 32'(0));

      // Stale done left high from the previous result.
      stale_mode = 1'b1;
      send(8'd11, 1'b1, 1'b1);
      wait_ready();
      repeat (18) tick();
      chk("stale_done_no_resp", 32'(resp_val), 32'(0));
      for (int k = 0; k < 100 && done; k++) tick();
      repeat (4) tick();
      chk("done_low_no_resp", 32'(resp_val), 32'(0));
      wait_resps();
      stale_mode = 1'b0;

      // Reset in the middle of a frame.
      send(8'h3C, 1'b0, 1'b0);
      for (int k = 0; k < 500 && rx_bits < 3; k++) tick();
      #2 reset = 1'b1;
      #1;
      chk("abort_cs", 32'(CS), 32'(1));
      chk("abort_sclk", 32'(SCLK), 32'(0));
      chk("abort_ready", 32'(ready), 32'(0));
      repeat (3) tick();
      chk("abort_resp_val", 32'(resp_val), 32'(0));
      reset = 1'b0;
      tick();
      chk("abort_req_rdy", 32'(req_rdy), 32'(1));
      repeat (40) tick();
      chk("abort_no_resp", 32'(resp_val), 32'(0));

      // Back-to-back operands.
      send(8'd2, 1'b1, 1'b1);
      send(8'd255, 1'b0, 1'b1);
      wait_resps();

      repeat (5) tick();
      chk("resp_queue_drained", 32'(exp_resp_q.size()), 32'(0));
      chk("frame_queue_drained", 32'(exp_word_q.size()), 32'(0));
      chk("resp_count", 32'(resp_count), 32'(n_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
